// File: rtl/circuit_command_writer_if.sv
// ---------------------------------------------------------------------------
// circuit_command_writer_if
//
// Bundles every non-clock, non-reset signal of the circuit command writer:
//   - element handshake: elem_valid/elem_ready plus type and coordinates
//   - list control: commit, clear
//   - command RAM write port: processor_addr, processor_wren, processor_in
//   - drawer handoff: ram_grant, numCommands, start_process, end_process,
//     draw_done
//   - status: busy, overflow, bad_elem
//
// Modports:
//   slave  - the writer itself (consumes elements, drives the RAM port)
//   master - the environment (element source, drawer, RAM)
// ---------------------------------------------------------------------------
interface circuit_command_writer_if;

    logic        elem_valid;
    logic        elem_ready;
    logic [2:0]  elem_type;
    logic [9:0]  elem_x0;
    logic [8:0]  elem_y0;
    logic [9:0]  elem_x1;
    logic [8:0]  elem_y1;
    logic        commit;
    logic        clear;
    logic [9:0]  processor_addr;
    logic        processor_wren;
    logic [47:0] processor_in;
    logic        ram_grant;
    logic [9:0]  numCommands;
    logic        start_process;
    logic        end_process;
    logic        draw_done;
    logic        busy;
    logic        overflow;
    logic        bad_elem;

    modport slave (
        input  elem_valid, elem_type, elem_x0, elem_y0, elem_x1, elem_y1,
        input  commit, clear, end_process,
        output elem_ready, processor_addr, processor_wren, processor_in,
        output ram_grant, numCommands, start_process, draw_done,
        output busy, overflow, bad_elem
    );

    modport master (
        output elem_valid, elem_type, elem_x0, elem_y0, elem_x1, elem_y1,
        output commit, clear, end_process,
        input  elem_ready, processor_addr, processor_wren, processor_in,
        input  ram_grant, numCommands, start_process, draw_done,
        input  busy, overflow, bad_elem
    );

endinterface

// File: rtl/circuit_command_writer.sv
// ---------------------------------------------------------------------------
// circuit_command_writer
//
// Producer side of the 1024x48 processor command RAM. Circuit elements
// arrive over a valid/ready handshake, are range-checked, packed into a
// 48-bit draw command and written at the next free address. On commit the
// RAM port and the command count are handed to the circuit drawer, which is
// kicked with start_process; when it answers with end_process the RAM is
// taken back and draw_done pulses.
//
// Ports:
//   clk            system clock
//   program_resetn asynchronous active-low reset
//   bus            circuit_command_writer_if.slave (handshake, RAM port,
//                  drawer handoff and status flags)
//
// Command word layout:
//   [47:45] type  [44:35] x0  [34:26] y0  [25:16] x1  [15:7] y1  [6:0] 0
// ---------------------------------------------------------------------------
module circuit_command_writer #(
    parameter int unsigned MAX_CMDS = 1023,
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480
) (
    input  logic                     clk,
    input  logic                     program_resetn,
    circuit_command_writer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        START,
        WAIT_DRAW,
        DONE
    } state_t;

    localparam logic [9:0] MaxCount = 10'(MAX_CMDS);

    state_t      state_q;
    logic [9:0]  count_q;
    logic [47:0] cmdWord_q;
    logic [47:0] cmdWord_d;
    logic [9:0]  addr_q;
    logic        wren_q;
    logic        grant_q;
    logic        start_q;
    logic        done_q;
    logic        overflow_q;
    logic        badElem_q;
    logic        elemLegal;
    logic        notFull;

    // Candidate command word and legality of the element currently offered.
    // Only the type code and the screen bounds matter; the word is captured
    // into cmdWord_q in the handshake cycle so WRITE never looks at the bus.
    always_comb begin
        cmdWord_d = {bus.elem_type, bus.elem_x0, bus.elem_y0,
                     bus.elem_x1, bus.elem_y1, 7'd0};
        elemLegal = (bus.elem_type <= 3'd4)
                 && (32'(bus.elem_x0) < H_RES) && (32'(bus.elem_x1) < H_RES)
                 && (32'(bus.elem_y0) < V_RES) && (32'(bus.elem_y1) < V_RES);
        notFull   = (count_q < MaxCount);
    end

    // Ready is withheld whenever clear or commit is present so that an
    // element can never be consumed in the same cycle as a list operation
    // that outranks it.
    assign bus.elem_ready     = (state_q == IDLE) && notFull
                             && !bus.clear && !bus.commit;
    assign bus.busy           = (state_q != IDLE);
    assign bus.numCommands    = count_q;
    assign bus.processor_addr = addr_q;
    assign bus.processor_wren = wren_q;
    assign bus.processor_in   = cmdWord_q;
    assign bus.ram_grant      = grant_q;
    assign bus.start_process  = start_q;
    assign bus.draw_done      = done_q;
    assign bus.overflow       = overflow_q;
    assign bus.bad_elem       = badElem_q;

    // Control FSM with registered outputs. Pulse outputs (wren, start,
    // draw_done) default low each cycle and are raised on the transition
    // into the state they belong to, so they are high exactly while the FSM
    // sits in that state. ram_grant drops on the way into START and comes
    // back on the way into DONE, which keeps wren (only raised from IDLE)
    // from ever overlapping drawer ownership.
    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cmdWord_q  <= '0;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            grant_q    <= 1'b1;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            badElem_q  <= 1'b0;
        end else begin
            wren_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        badElem_q  <= 1'b0;
                    end else if (bus.commit) begin
                        // An empty list has nothing to draw, so the drawer
                        // is never woken and completion is reported at once.
                        if (count_q == 10'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= START;
                            start_q <= 1'b1;
                            grant_q <= 1'b0;
                        end
                    end else if (bus.elem_valid) begin
                        if (!notFull) begin
                            overflow_q <= 1'b1;
                        end else if (elemLegal) begin
                            cmdWord_q <= cmdWord_d;
                            addr_q    <= count_q;
                            wren_q    <= 1'b1;
                            state_q   <= WRITE;
                        end else begin
                            badElem_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    count_q <= count_q + 10'd1;
                    state_q <= IDLE;
                end
                START: begin
                    // end_process is deliberately not looked at here; a
                    // stale level from the previous draw must not end this one.
                    state_q <= WAIT_DRAW;
                end
                WAIT_DRAW: begin
                    if (bus.end_process) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        grant_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuit_command_writer.sv
// ---------------------------------------------------------------------------
// tb_circuit_command_writer
//
// Directed bench for circuit_command_writer with capacity reduced to 4 so the
// full-list case is reachable. Inputs change 1 ns after the rising edge and
// outputs are checked at the same point, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_circuit_command_writer;

    logic clk;
    logic program_resetn;
    int   totalCount;
    int   badCount;

    circuit_command_writer_if bus ();

    circuit_command_writer #(
        .MAX_CMDS (4),
        .H_RES    (640),
        .V_RES    (480)
    ) dut (
        .clk            (clk),
        .program_resetn (program_resetn),
        .bus            (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference packing of a draw command, written from the word layout.
    function automatic logic [47:0] packCmd(input logic [2:0] t,
                                            input logic [9:0] x0,
                                            input logic [8:0] y0,
                                            input logic [9:0] x1,
                                            input logic [8:0] y1);
        return {t, x0, y0, x1, y1, 7'd0};
    endfunction

    // Presents one element on the handshake inputs.
    task automatic applyStimulus(input logic       valid,
                                 input logic [2:0] t,
                                 input logic [9:0] x0,
                                 input logic [8:0] y0,
                                 input logic [9:0] x1,
                                 input logic [8:0] y1);
        bus.elem_valid = valid;
        bus.elem_type  = t;
        bus.elem_x0    = x0;
        bus.elem_y0    = y0;
        bus.elem_x1    = x1;
        bus.elem_y1    = y1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag,
                               input logic [47:0] observed,
                               input logic [47:0] expected);
        totalCount++;
        assert (observed === expected)
        else begin
            badCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  tTab  [3];
        logic [9:0]  x0Tab [3];
        logic [8:0]  y0Tab [3];
        logic [9:0]  x1Tab [3];
        logic [8:0]  y1Tab [3];

        totalCount = 0;
        badCount   = 0;
        program_resetn  = 1'b0;
        bus.commit      = 1'b0;
        bus.clear       = 1'b0;
        bus.end_process = 1'b0;
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);

        // ---------------- reset values ----------------
        #12;
        checkOutput("rst_grant",    48'(bus.ram_grant),      48'd1);
        checkOutput("rst_wren",     48'(bus.processor_wren), 48'd0);
        checkOutput("rst_count",    48'(bus.numCommands),    48'd0);
        checkOutput("rst_busy",     48'(bus.busy),           48'd0);
        checkOutput("rst_start",    48'(bus.start_process),  48'd0);
        checkOutput("rst_done",     48'(bus.draw_done),      48'd0);
        checkOutput("rst_overflow", 48'(bus.overflow),       48'd0);
        checkOutput("rst_bad",      48'(bus.bad_elem),       48'd0);
        tick();
        program_resetn = 1'b1;
        #1;
        checkOutput("rst_ready", 48'(bus.elem_ready), 48'd1);

        // ---------------- single element ----------------
        applyStimulus(1'b1, 3'd3, 10'd100, 9'd50, 10'd140, 9'd50);
        tick();
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        checkOutput("one_wren",  48'(bus.processor_wren), 48'd1);
        checkOutput("one_addr",  48'(bus.processor_addr), 48'd0);
        checkOutput("one_data",  bus.processor_in,        48'h6320_C88C_1900);
        checkOutput("one_ready", 48'(bus.elem_ready),     48'd0);
        tick();
        checkOutput("one_count", 48'(bus.numCommands),    48'd1);
        checkOutput("one_wren0", 48'(bus.processor_wren), 48'd0);

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checkOutput("clr1_count", 48'(bus.numCommands), 48'd0);

        // ---------------- stream of 3, valid held high ----------------
        tTab[0] = 3'd0; x0Tab[0] = 10'd10;  y0Tab[0] = 9'd20;  x1Tab[0] = 10'd30; y1Tab[0] = 9'd40;
        tTab[1] = 3'd1; x0Tab[1] = 10'd639; y0Tab[1] = 9'd479; x1Tab[1] = 10'd0;  y1Tab[1] = 9'd0;
        tTab[2] = 3'd4; x0Tab[2] = 10'd5;   y0Tab[2] = 9'd6;   x1Tab[2] = 10'd5;  y1Tab[2] = 9'd6;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, tTab[i], x0Tab[i], y0Tab[i], x1Tab[i], y1Tab[i]);
            #1;
            checkOutput($sformatf("str%0d_ready1", i), 48'(bus.elem_ready), 48'd1);
            tick();
            checkOutput($sformatf("str%0d_ready0", i), 48'(bus.elem_ready), 48'd0);
            checkOutput($sformatf("str%0d_wren", i), 48'(bus.processor_wren), 48'd1);
            checkOutput($sformatf("str%0d_addr", i), 48'(bus.processor_addr), 48'(i));
            checkOutput($sformatf("str%0d_data", i), bus.processor_in,
                        packCmd(tTab[i], x0Tab[i], y0Tab[i], x1Tab[i], y1Tab[i]));
            tick();
        end
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        checkOutput("str_count", 48'(bus.numCommands), 48'd3);

        // ---------------- illegal elements ----------------
        applyStimulus(1'b1, 3'd0, 10'd1, 9'd1, 10'd640, 9'd1);
        tick();
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        checkOutput("badx_wren",  48'(bus.processor_wren), 48'd0);
        checkOutput("badx_flag",  48'(bus.bad_elem),       48'd1);
        checkOutput("badx_busy",  48'(bus.busy),           48'd0);
        checkOutput("badx_count", 48'(bus.numCommands),    48'd3);
        applyStimulus(1'b1, 3'd6, 10'd1, 9'd1, 10'd2, 9'd2);
        tick();
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        checkOutput("badt_wren",  48'(bus.processor_wren), 48'd0);
        tick();
        checkOutput("badt_count", 48'(bus.numCommands),    48'd3);

        // ---------------- commit with 3 commands ----------------
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        checkOutput("c1_start",  48'(bus.start_process), 48'd1);
        checkOutput("c1_grantS", 48'(bus.ram_grant),     48'd0);
        checkOutput("c1_count",  48'(bus.numCommands),   48'd3);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) begin
                bus.clear = 1'b1;
                applyStimulus(1'b1, 3'd0, 10'd1, 9'd1, 10'd1, 9'd1);
            end
            tick();
            checkOutput($sformatf("c1_w%0d_start", i), 48'(bus.start_process), 48'd0);
            checkOutput($sformatf("c1_w%0d_grant", i), 48'(bus.ram_grant), 48'd0);
            checkOutput($sformatf("c1_w%0d_wren", i), 48'(bus.processor_wren), 48'd0);
            checkOutput($sformatf("c1_w%0d_ready", i), 48'(bus.elem_ready), 48'd0);
            bus.clear = 1'b0;
            applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        end
        checkOutput("c1_ignclr", 48'(bus.numCommands), 48'd3);
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        checkOutput("c1_done",  48'(bus.draw_done), 48'd1);
        checkOutput("c1_grantD", 48'(bus.ram_grant), 48'd1);
        tick();
        checkOutput("c1_done0", 48'(bus.draw_done),   48'd0);
        checkOutput("c1_busy0", 48'(bus.busy),        48'd0);
        checkOutput("c1_keep",  48'(bus.numCommands), 48'd3);

        // ---------------- redraw; end_process during START ignored ----------------
        bus.commit = 1'b1;
        tick();
        bus.commit      = 1'b0;
        bus.end_process = 1'b1;
        checkOutput("c2_start", 48'(bus.start_process), 48'd1);
        tick();
        bus.end_process = 1'b0;
        checkOutput("c2_nodone", 48'(bus.draw_done), 48'd0);
        checkOutput("c2_busy",   48'(bus.busy),      48'd1);
        tick();
        checkOutput("c2_wait",   48'(bus.ram_grant), 48'd0);
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        checkOutput("c2_done", 48'(bus.draw_done), 48'd1);
        tick();

        // ---------------- clear resets flags and count ----------------
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checkOutput("clr2_bad",   48'(bus.bad_elem),    48'd0);
        checkOutput("clr2_count", 48'(bus.numCommands), 48'd0);

        // ---------------- fill to capacity, then overflow ----------------
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'd2, 10'(i), 9'd7, 10'd8, 9'd9);
            tick();
            applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
            tick();
        end
        checkOutput("full_count", 48'(bus.numCommands), 48'd4);
        applyStimulus(1'b1, 3'd2, 10'd1, 9'd1, 10'd1, 9'd1);
        #1;
        checkOutput("full_ready", 48'(bus.elem_ready), 48'd0);
        tick();
        checkOutput("full_ovf",   48'(bus.overflow),       48'd1);
        checkOutput("full_wren",  48'(bus.processor_wren), 48'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        checkOutput("full_wren2", 48'(bus.processor_wren), 48'd0);
        checkOutput("full_cnt2",  48'(bus.numCommands),    48'd4);

        // ---------------- commit on empty list ----------------
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checkOutput("clr3_ovf", 48'(bus.overflow), 48'd0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        checkOutput("empty_done",  48'(bus.draw_done),     48'd1);
        checkOutput("empty_start", 48'(bus.start_process), 48'd0);
        checkOutput("empty_grant", 48'(bus.ram_grant),     48'd1);
        tick();
        checkOutput("empty_done0", 48'(bus.draw_done), 48'd0);

        // ---------------- reset during WAIT_DRAW ----------------
        applyStimulus(1'b1, 3'd1, 10'd3, 9'd3, 10'd4, 9'd4);
        tick();
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        tick();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        checkOutput("rw_grant0", 48'(bus.ram_grant), 48'd0);
        #3;
        program_resetn = 1'b0;
        #1;
        checkOutput("rw_start", 48'(bus.start_process), 48'd0);
        checkOutput("rw_grant", 48'(bus.ram_grant),     48'd1);
        checkOutput("rw_count", 48'(bus.numCommands),   48'd0);
        checkOutput("rw_busy",  48'(bus.busy),          48'd0);
        tick();
        program_resetn = 1'b1;

        // ---------------- clear and commit together ----------------
        applyStimulus(1'b1, 3'd1, 10'd3, 9'd3, 10'd4, 9'd4);
        tick();
        applyStimulus(1'b0, 3'd0, 10'd0, 9'd0, 10'd0, 9'd0);
        tick();
        checkOutput("cc_pre", 48'(bus.numCommands), 48'd1);
        bus.clear  = 1'b1;
        bus.commit = 1'b1;
        #1;
        checkOutput("cc_ready", 48'(bus.elem_ready), 48'd0);
        tick();
        bus.clear  = 1'b0;
        bus.commit = 1'b0;
        checkOutput("cc_start", 48'(bus.start_process), 48'd0);
        checkOutput("cc_busy",  48'(bus.busy),          48'd0);
        checkOutput("cc_count", 48'(bus.numCommands),   48'd0);
        checkOutput("cc_done",  48'(bus.draw_done),     48'd0);
        tick();
        checkOutput("cc_start2", 48'(bus.start_process), 48'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
